fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter for the single write port of the TX async FIFO.
- Two requesters share the port:
  - Requester A: register-file read responses, 8-bit.
  - Requester B: ALU results, 16-bit, sent as two bytes.
- Serialises each granted transaction into byte writes, throttled by `FIFO_FULL`.
- Sits in the `CLK` domain between the system controller's response path and the FIFO write side. It replaces the level-to-pulse conversion on the write increment.

---
 rtl/fifo_wr_arbiter_if.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 107 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the FIFO write side.
// Signals: REQ/DATA/ACK for A and B, FIFO_FULL, WR_INC, WR_DATA_FIFO, ARB_BUSY, GRANT_SRC.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    REQ_A;
    logic [DATA_WIDTH-1:0]   DATA_A;
    logic                    ACK_A;
    logic                    REQ_B;
    logic [2*DATA_WIDTH-1:0] DATA_B;
    logic                    ACK_B;
    logic                    FIFO_FULL;
    logic                    WR_INC;
    logic [DATA_WIDTH-1:0]   WR_DATA_FIFO;
    logic                    ARB_BUSY;
    logic                    GRANT_SRC;

    // Requester / FIFO side
    modport master (
        output REQ_A, DATA_A, REQ_B, DATA_B, FIFO_FULL,
        input  ACK_A, ACK_B, WR_INC, WR_DATA_FIFO, ARB_BUSY, GRANT_SRC
    );

    // Arbiter side
    modport slave (
        input  REQ_A, DATA_A, REQ_B, DATA_B, FIFO_FULL,
        output ACK_A, ACK_B, WR_INC, WR_DATA_FIFO, ARB_BUSY, GRANT_SRC
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter serialising A (1 byte) and B (2 byte) transactions into FIFO writes.
// Ports: CLK, RST (sync, active-high), bus (slave modport of fifo_wr_arbiter_if).
// Optional macro FIFO_ARB_TAG_EN prefixes each transaction with TAG_A / TAG_B.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8
`ifdef FIFO_ARB_TAG_EN
    ,
    parameter logic [DATA_WIDTH-1:0] TAG_A = 'hA1,
    parameter logic [DATA_WIDTH-1:0] TAG_B = 'hB2
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int HW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2
`ifdef FIFO_ARB_TAG_EN
        ,
        TAG   = 2'd3
`endif
    } state_t;

    state_t                state;
    logic [HW-1:0]         holding;
    logic                  last_b;
    logic                  ack_a;
    logic                  ack_b;
    logic                  grant_src;
    logic                  pick_b;
    logic                  wr_inc;
    logic [DATA_WIDTH-1:0] wr_data;

    // B wins if it is alone, or on a tie when A was served last.
    assign pick_b = bus.REQ_B && (!bus.REQ_A || !last_b);

    // A write happens in any send cycle the FIFO can take it; reset kills it at once.
    assign wr_inc = (state != IDLE) && !bus.FIFO_FULL && !RST;

    always_comb begin
        wr_data = '0;
        if (wr_inc) begin
            unique case (state)
`ifdef FIFO_ARB_TAG_EN
                TAG:     wr_data = grant_src ? TAG_B : TAG_A;
`endif
                BYTE0:   wr_data = holding[DATA_WIDTH-1:0];
                BYTE1:   wr_data = holding[HW-1:DATA_WIDTH];
                default: wr_data = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            holding   <= '0;
            last_b    <= 1'b1;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            grant_src <= 1'b0;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.REQ_A || bus.REQ_B) begin
                        grant_src <= pick_b;
                        last_b    <= pick_b;
                        ack_a     <= !pick_b;
                        ack_b     <= pick_b;
                        holding   <= pick_b ? bus.DATA_B
                                            : {{DATA_WIDTH{1'b0}}, bus.DATA_A};
`ifdef FIFO_ARB_TAG_EN
                        state     <= TAG;
`else
                        state     <= BYTE0;
`endif
                    end
                end
`ifdef FIFO_ARB_TAG_EN
                TAG: begin
                    if (wr_inc) state <= BYTE0;
                end
`endif
                BYTE0: begin
                    if (wr_inc) state <= grant_src ? BYTE1 : IDLE;
                end
                BYTE1: begin
                    if (wr_inc) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ACK_A        = ack_a;
    assign bus.ACK_B        = ack_b;
    assign bus.WR_INC       = wr_inc;
    assign bus.WR_DATA_FIFO = wr_data;
    assign bus.ARB_BUSY     = (state != IDLE);
    assign bus.GRANT_SRC    = grant_src;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single A/B, tie fairness,
// backpressure, reset mid-B (default build) or tag prefixes (FIFO_ARB_TAG_EN).
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fifo_wr_arbiter_if #(.DATA_WIDTH(8)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every output against hand-computed values.
    task automatic expect_o(input string tag, input logic ea, input logic eb,
                            input logic ewr, input logic [7:0] ed,
                            input logic ebusy, input logic egrant);
        #1;
        chk({tag, ".ack_a"}, {7'd0, bus.ACK_A}, {7'd0, ea});
        chk({tag, ".ack_b"}, {7'd0, bus.ACK_B}, {7'd0, eb});
        chk({tag, ".wr_inc"}, {7'd0, bus.WR_INC}, {7'd0, ewr});
        chk({tag, ".wr_data"}, bus.WR_DATA_FIFO, ed);
        chk({tag, ".busy"}, {7'd0, bus.ARB_BUSY}, {7'd0, ebusy});
        chk({tag, ".grant"}, {7'd0, bus.GRANT_SRC}, {7'd0, egrant});
    endtask

    initial begin
        bus.REQ_A     = 1'b0;
        bus.DATA_A    = 8'h00;
        bus.REQ_B     = 1'b0;
        bus.DATA_B    = 16'h0000;
        bus.FIFO_FULL = 1'b0;
        rst = 1'b1;
        step();
        step();
        expect_o("reset", 0, 0, 0, 8'h00, 0, 0);
        rst = 1'b0;
        step();
        expect_o("idle", 0, 0, 0, 8'h00, 0, 0);

`ifdef FIFO_ARB_TAG_EN
        bus.REQ_A = 1'b1; bus.DATA_A = 8'h7E;
        step();
        expect_o("tagA.tag", 1, 0, 1, 8'hA1, 1, 0);
        bus.REQ_A = 1'b0;
        step();
        expect_o("tagA.b0", 0, 0, 1, 8'h7E, 1, 0);
        step();
        expect_o("tagA.idle", 0, 0, 0, 8'h00, 0, 0);

        bus.REQ_B = 1'b1; bus.DATA_B = 16'h0102;
        step();
        expect_o("tagB.tag", 0, 1, 1, 8'hB2, 1, 1);
        bus.REQ_B = 1'b0;
        step();
        expect_o("tagB.b0", 0, 0, 1, 8'h02, 1, 1);
        step();
        expect_o("tagB.b1", 0, 0, 1, 8'h01, 1, 1);
        step();
        expect_o("tagB.idle", 0, 0, 0, 8'h00, 0, 1);
`else
        // Single A
        bus.REQ_A = 1'b1; bus.DATA_A = 8'h3C;
        step();
        expect_o("singleA.b0", 1, 0, 1, 8'h3C, 1, 0);
        bus.REQ_A = 1'b0;
        step();
        expect_o("singleA.idle", 0, 0, 0, 8'h00, 0, 0);

        // Single B
        bus.REQ_B = 1'b1; bus.DATA_B = 16'hBEEF;
        step();
        expect_o("singleB.b0", 0, 1, 1, 8'hEF, 1, 1);
        bus.REQ_B = 1'b0;
        step();
        expect_o("singleB.b1", 0, 0, 1, 8'hBE, 1, 1);
        step();
        expect_o("singleB.idle", 0, 0, 0, 8'h00, 0, 1);

        // Tie from reset: A, then B, then B's repeat waits behind A's repeat
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.REQ_A = 1'b1; bus.DATA_A = 8'h11;
        bus.REQ_B = 1'b1; bus.DATA_B = 16'h2233;
        step();
        expect_o("tie.a", 1, 0, 1, 8'h11, 1, 0);
        bus.REQ_A = 1'b0;
        step();
        expect_o("tie.gap1", 0, 0, 0, 8'h00, 0, 0);
        bus.REQ_A = 1'b1; bus.DATA_A = 8'h44;
        step();
        expect_o("tie.b0", 0, 1, 1, 8'h33, 1, 1);
        bus.REQ_B = 1'b0;
        step();
        expect_o("tie.b1", 0, 0, 1, 8'h22, 1, 1);
        bus.REQ_B = 1'b1; bus.DATA_B = 16'h5566;
        step();
        expect_o("tie.gap2", 0, 0, 0, 8'h00, 0, 1);
        step();
        expect_o("tie.a2", 1, 0, 1, 8'h44, 1, 0);
        bus.REQ_A = 1'b0;
        step();
        expect_o("tie.gap3", 0, 0, 0, 8'h00, 0, 0);
        step();
        expect_o("tie.b2lo", 0, 1, 1, 8'h66, 1, 1);
        bus.REQ_B = 1'b0;
        step();
        expect_o("tie.b2hi", 0, 0, 1, 8'h55, 1, 1);
        step();
        expect_o("tie.idle", 0, 0, 0, 8'h00, 0, 1);

        // Backpressure on the high byte
        bus.REQ_B = 1'b1; bus.DATA_B = 16'hA55A;
        step();
        expect_o("bp.b0", 0, 1, 1, 8'h5A, 1, 1);
        bus.REQ_B = 1'b0;
        step();
        bus.FIFO_FULL = 1'b1;
        expect_o("bp.stall1", 0, 0, 0, 8'h00, 1, 1);
        step();
        expect_o("bp.stall2", 0, 0, 0, 8'h00, 1, 1);
        step();
        expect_o("bp.stall3", 0, 0, 0, 8'h00, 1, 1);
        step();
        bus.FIFO_FULL = 1'b0;
        expect_o("bp.b1", 0, 0, 1, 8'hA5, 1, 1);
        step();
        expect_o("bp.idle", 0, 0, 0, 8'h00, 0, 1);

        // Reset in the BYTE1 cycle
        bus.REQ_B = 1'b1; bus.DATA_B = 16'hC3D4;
        step();
        expect_o("rstB.b0", 0, 1, 1, 8'hD4, 1, 1);
        bus.REQ_B = 1'b0;
        step();
        rst = 1'b1;
        expect_o("rstB.b1", 0, 0, 0, 8'h00, 1, 1);
        step();
        rst = 1'b0;
        expect_o("rstB.after", 0, 0, 0, 8'h00, 0, 0);
        step();
        expect_o("rstB.quiet", 0, 0, 0, 8'h00, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
